// File: rtl/core_types.sv
// core_types: request bundle shared between the pipeline and the data-memory path.
package core_types;
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [3:0]            sel;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } dmem_req_t;
  function automatic logic [REQ_ADDR_W-1:0] word_align(input logic [REQ_ADDR_W-1:0] a);
    return a & ~REQ_ADDR_W'(3);
  endfunction
endpackage

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory FSM bridging pipeline requests to a read/write backend.
module dmem_responder
  import core_types::*;
#(
  parameter int ADDR_W = REQ_ADDR_W,
  parameter int DATA_W = REQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [3:0]        req_sel,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] ret_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_rdy,
  input  logic              wr_resp
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP} state_t;
  state_t            state_q, state_d;
  dmem_req_t         req_q, req_d;
  logic              cancel_q, cancel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept;
  assign accept = state_q == IDLE && req_valid && !flush;
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cancel_d = cancel_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        state_d = accept ? (req_we ? WR_REQ : RD_REQ) : IDLE;
        req_d   = accept ? '{valid: 1'b1, we: req_we, sel: req_sel, addr: req_addr, wdata: req_wdata} : req_q;
      end
      RD_REQ: begin
        state_d  = rd_rdy ? RD_WAIT : flush ? IDLE : RD_REQ;
        cancel_d = cancel_q | (flush & rd_rdy);
      end
      RD_WAIT: begin
        cancel_d = cancel_q | flush;
        state_d  = ret_valid ? RESP : RD_WAIT;
        rdata_d  = (ret_valid && !cancel_d) ? ret_data : rdata_q;
      end
      WR_REQ: begin
        state_d  = wr_rdy ? WR_WAIT : flush ? IDLE : WR_REQ;
        cancel_d = cancel_q | (flush & wr_rdy);
      end
      WR_WAIT: begin
        cancel_d = cancel_q | flush;
        state_d  = wr_resp ? RESP : WR_WAIT;
      end
      RESP: begin
        state_d  = IDLE;
        cancel_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cancel_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cancel_q <= cancel_d;
      rdata_q  <= rdata_d;
    end
  end
  // Outputs are forced low while rst is held, before the flops have cleared.
  assign addr_ok = !rst && accept;
  assign data_ok = !rst && state_q == RESP && !cancel_q && !flush;
  assign rd_req  = !rst && state_q == RD_REQ && req_q.valid && !req_q.we;
  assign wr_req  = !rst && state_q == WR_REQ && req_q.valid && req_q.we;
  assign rd_addr = rst ? '0 : word_align(req_q.addr);
  assign wr_addr = rst ? '0 : word_align(req_q.addr);
  assign wr_data = rst ? '0 : req_q.wdata;
  assign wr_strb = rst ? '0 : req_q.sel;
  assign rdata   = rst ? '0 : rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: transaction-level model compared every cycle, plus directed literal checks.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, flush, rd_rdy, ret_valid, wr_rdy, wr_resp;
  logic [3:0]  req_sel;
  logic [31:0] req_addr, req_wdata, ret_data;
  logic        addr_ok, data_ok, rd_req, wr_req;
  logic [31:0] rdata, rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_strb;
  int n_cmp = 0, n_bad = 0, dok_cnt = 0, dok0 = 0;

  dmem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_rdy(wr_rdy), .wr_resp(wr_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction model: one outstanding request, tracked as handshake/return milestones.
  logic        m_busy = 0, m_we = 0, m_hs = 0, m_ret = 0, m_cancel = 0;
  logic [3:0]  m_sel = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  always @(posedge clk) begin
    if (rst) begin
      {m_busy, m_we, m_hs, m_ret, m_cancel} = '0;
      m_sel = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    end else if (!m_busy) begin
      if (req_valid && !flush) begin
        m_busy = 1; m_hs = 0; m_ret = 0; m_cancel = 0;
        m_we = req_we; m_sel = req_sel; m_addr = req_addr; m_wdata = req_wdata;
      end
    end else if (!m_hs) begin
      if (m_we ? wr_rdy : rd_rdy) begin
        m_hs = 1;
        m_cancel = m_cancel | flush;
      end else if (flush) m_busy = 0;
    end else if (!m_ret) begin
      m_cancel = m_cancel | flush;
      if (m_we ? wr_resp : ret_valid) begin
        m_ret = 1;
        if (!m_we && !m_cancel) m_rdata = ret_data;
      end
    end else begin
      m_busy = 0; m_hs = 0; m_ret = 0; m_cancel = 0;
    end
  end

  always @(negedge clk) begin
    chk("addr_ok", 32'(addr_ok), 32'(!rst && !m_busy && req_valid && !flush));
    chk("data_ok", 32'(data_ok), 32'(!rst && m_ret && !m_cancel && !flush));
    chk("rd_req", 32'(rd_req), 32'(!rst && m_busy && !m_we && !m_hs));
    chk("wr_req", 32'(wr_req), 32'(!rst && m_busy && m_we && !m_hs));
    chk("rd_addr", rd_addr, rst ? 32'h0 : m_addr & ~32'h3);
    chk("wr_addr", wr_addr, rst ? 32'h0 : m_addr & ~32'h3);
    chk("wr_data", wr_data, rst ? 32'h0 : m_wdata);
    chk("wr_strb", 32'(wr_strb), rst ? 32'h0 : 32'(m_sel));
    chk("rdata", rdata, rst ? 32'h0 : m_rdata);
    chk("one_hot_req", 32'(rd_req && wr_req), 32'h0);
    if (data_ok === 1'b1) dok_cnt++;
  end

  task automatic nx; @(posedge clk); #1; endtask
  task automatic ng; @(negedge clk); endtask
  task automatic set_req(input logic we, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1; req_we = we; req_sel = sel; req_addr = a; req_wdata = d;
  endtask

  initial begin
    rst = 1; flush = 0; rd_rdy = 0; ret_valid = 0; wr_rdy = 0; wr_resp = 0; ret_data = 0;
    set_req(1, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    ng; chk("rst_addr_ok", 32'(addr_ok), 0); chk("rst_wr_data", wr_data, 0);
    nx; nx; rst = 0; req_valid = 0;
    ng; chk("post_rst_rdata", rdata, 0); chk("post_rst_wr_strb", 32'(wr_strb), 0); nx;
    // Minimum-latency load
    set_req(0, 4'hF, 32'h1C00_0005, 0);
    ng; chk("A_addr_ok", 32'(addr_ok), 1); nx;
    req_valid = 0; rd_rdy = 1;
    ng; chk("A_rd_req", 32'(rd_req), 1); chk("A_rd_addr", rd_addr, 32'h1C00_0004); nx;
    rd_rdy = 0; ret_valid = 1; ret_data = 32'hAABB_CCDD;
    ng; chk("A_no_early_ok", 32'(data_ok), 0); nx;
    ret_valid = 0;
    ng; chk("A_data_ok", 32'(data_ok), 1); chk("A_rdata", rdata, 32'hAABB_CCDD); nx;
    // Store with backend stalling
    set_req(1, 4'b0100, 32'h0000_0102, 32'h5A5A_5A5A); nx; req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      ng; chk("B_wr_req", 32'(wr_req), 1); chk("B_wr_addr", wr_addr, 32'h100);
      chk("B_wr_strb", 32'(wr_strb), 32'h4); chk("B_wr_data", wr_data, 32'h5A5A_5A5A); nx;
    end
    wr_rdy = 1; ng; chk("B_wr_req_hs", 32'(wr_req), 1); nx;
    wr_rdy = 0; ng; chk("B_wait_no_req", 32'(wr_req), 0); nx;
    wr_resp = 1; nx; wr_resp = 0;
    ng; chk("B_data_ok", 32'(data_ok), 1); chk("B_rdata_held", rdata, 32'hAABB_CCDD); nx;
    // Flush in RD_REQ with a pending request behind it
    set_req(0, 4'hF, 32'h40, 0); nx;
    set_req(0, 4'hF, 32'h80, 0); flush = 1;
    ng; chk("C_no_accept_busy", 32'(addr_ok), 0); nx;
    flush = 0;
    ng; chk("C_reaccept", 32'(addr_ok), 1); chk("C_no_data_ok", 32'(data_ok), 0); nx;
    req_valid = 0; rd_rdy = 1; ng; chk("C_rd_addr", rd_addr, 32'h80); nx;
    rd_rdy = 0; ret_valid = 1; ret_data = 32'h1122_3344; nx; ret_valid = 0;
    ng; chk("C_data_ok", 32'(data_ok), 1); chk("C_rdata", rdata, 32'h1122_3344); nx;
    // Flush in RD_WAIT, late return
    set_req(0, 4'hF, 32'h200, 0); nx;
    req_valid = 0; rd_rdy = 1; nx;
    rd_rdy = 0; flush = 1; nx;
    flush = 0; nx;
    ret_valid = 1; ret_data = 32'hDEAD_BEEF; nx; ret_valid = 0;
    ng; chk("D_no_data_ok", 32'(data_ok), 0); chk("D_rdata_held", rdata, 32'h1122_3344); nx;
    // Back-to-back load then store, req_valid held
    set_req(0, 4'hF, 32'h300, 0);
    ng; chk("D_idle_accept", 32'(addr_ok), 1); dok0 = dok_cnt; nx;
    set_req(1, 4'hF, 32'h304, 32'h0102_0304); rd_rdy = 1;
    ng; chk("E_hold_rdreq", 32'(addr_ok), 0); nx;
    rd_rdy = 0; ret_valid = 1; ret_data = 32'h0BAD_F00D;
    ng; chk("E_hold_rdwait", 32'(addr_ok), 0); nx;
    ret_valid = 0;
    ng; chk("E_data_ok1", 32'(data_ok), 1); chk("E_hold_resp", 32'(addr_ok), 0); nx;
    ng; chk("E_second_accept", 32'(addr_ok), 1); nx;
    req_valid = 0; wr_rdy = 1; nx;
    wr_rdy = 0; wr_resp = 1; nx; wr_resp = 0;
    ng; chk("E_data_ok2", 32'(data_ok), 1); chk("E_rdata", rdata, 32'h0BAD_F00D); nx;
    chk("E_pulses", 32'(dok_cnt - dok0), 2);
    // Zero-strobe store still completes
    set_req(1, 4'h0, 32'h3, 32'hCAFE_BABE); nx;
    req_valid = 0; wr_rdy = 1;
    ng; chk("F1_wr_strb", 32'(wr_strb), 0); chk("F1_wr_addr", wr_addr, 0); nx;
    wr_rdy = 0; wr_resp = 1; nx; wr_resp = 0;
    ng; chk("F1_data_ok", 32'(data_ok), 1); nx;
    // Flush during RESP
    set_req(0, 4'hF, 32'h500, 0); nx;
    req_valid = 0; rd_rdy = 1; nx;
    rd_rdy = 0; ret_valid = 1; ret_data = 32'h5566_7788; nx;
    ret_valid = 0; flush = 1;
    ng; chk("F2_no_data_ok", 32'(data_ok), 0); chk("F2_rdata", rdata, 32'h5566_7788); nx;
    flush = 0;
    // Flush together with wr_rdy
    set_req(1, 4'hF, 32'h600, 32'h7777_7777); nx;
    req_valid = 0; wr_rdy = 1; flush = 1; nx;
    wr_rdy = 0; flush = 0; ng; chk("F3_no_wr_req", 32'(wr_req), 0); nx;
    wr_resp = 1; nx; wr_resp = 0;
    ng; chk("F3_no_data_ok", 32'(data_ok), 0); nx;
    // Flush and req_valid together in IDLE
    set_req(0, 4'hF, 32'h700, 0); flush = 1;
    ng; chk("F4_no_accept", 32'(addr_ok), 0); nx;
    req_valid = 0; flush = 0; ng; chk("F4_no_rd_req", 32'(rd_req), 0); nx;
    // Reset in WR_WAIT, late wr_resp and ret_valid ignored
    set_req(1, 4'hF, 32'h800, 32'h1234_5678); nx;
    req_valid = 0; wr_rdy = 1; nx;
    wr_rdy = 0; rst = 1;
    ng; chk("G_rst_wr_data", wr_data, 0); chk("G_rst_wr_addr", wr_addr, 0); nx;
    rst = 0; wr_resp = 1;
    ng; chk("G_no_data_ok", 32'(data_ok), 0); chk("G_wr_data", wr_data, 0); nx;
    wr_resp = 0; ret_valid = 1; ret_data = 32'hFFFF_FFFF; nx; ret_valid = 0;
    ng; chk("G_rdata_zero", rdata, 0); chk("G_data_ok_zero", 32'(data_ok), 0); nx;
    nx;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
